dropout_ctrl: RTL and testbench
===============================

Name: dropout_ctrl

Overview:
Sequencer for the dropout stage of the 8-neuron layer. Per sample it latches a dropout rate and derives an 8-bit keep mask from an internal 16-bit Galois LFSR, one LFSR step per neuron. It then streams the 8 neuron activations through a valid/ready handshake, zeroing dropped lanes. When ui_ena is low at the start of a sample, the block is a pure pass-through (inference mode). It replaces the simulation-only random calls with a synthesizable, seedable generator.

Parameters:
N_NEURONS, 8, neurons per sample; also the mask width.
DATA_W, 8, activation width.
LFSR_W, 16, LFSR width.
LFSR_POLY, 16'hB400, Galois feedback mask for x^16+x^14+x^13+x^11+1.
LFSR_SEED, 16'hACE1, reset seed and the substitute for a zero seed.

Ports:
clk  in  1  clock; all state updates on the rising edge
rst_n  in  1  asynchronous active-low reset
ui_ena  in  1  training enable, sampled on start
rate_i  in  8  dropout threshold; a lane is dropped if the LFSR upper byte is less than the rate
seed_load  in  1  load seed_val into the LFSR (accepted in IDLE only)
seed_val  in  16  seed value
start  in  1  begin one sample (accepted in IDLE only)
in_valid  in  1  upstream activation valid
in_data  in  DATA_W  activation for the current neuron index
in_ready  out  1  upstream ready
out_valid  out  1  downstream valid
out_data  out  DATA_W  masked activation
out_ready  in  1  downstream ready
mask_o  out  N_NEURONS  current keep mask (1 = keep)
busy  out  1  high whenever state is not IDLE
done  out  1  one-cycle pulse when a sample completes

Behaviour:
- Reset values: LFSR=LFSR_SEED, state=IDLE, mask_o=0xFF, out_valid=0, out_data=0, in_ready=0, busy=0, done=0, rate register=0, index=0.
- FSM states are IDLE, GEN, APPLY, FLUSH.
- IDLE:
  - in_ready=0.
  - seed_load takes priority over start in the same cycle. It loads seed_val, or LFSR_SEED if seed_val==0, because the all-zero state locks the LFSR. The start is ignored.
  - start with ui_ena=1: latch rate_i, clear index, go to GEN.
  - start with ui_ena=0: mask_o<=0xFF, go to APPLY; the LFSR does not advance.
- GEN, 8 cycles, index i=0..7:
  - LFSR step: next = (s>>1) ^ (s[0] ? LFSR_POLY : 0).
  - mask bit i <= (next[15:8] >= rate), computed on the post-step state.
  - After i=7, clear index and go to APPLY.
  - rate=0 never drops. rate=0xFF drops unless the upper byte is 0xFF.
- APPLY: single output register.
  - in_ready = !out_valid || out_ready.
  - On in_valid && in_ready: out_data <= mask[index] ? in_data : 0, out_valid<=1, index++.
  - On out_valid && out_ready with no new load: out_valid<=0.
  - When the beat with index 7 is accepted, go to FLUSH.
- FLUSH:
  - in_ready=0.
  - When the last beat is taken (out_valid && out_ready), pulse done the following cycle and return to IDLE.
- Latency: 1 cycle from input acceptance to out_valid. Full throughput (1 beat/cycle) when out_ready is held high.
- Sample start to first in_ready: 9 cycles in training mode, 1 cycle in pass-through.
- Changes to rate_i, ui_ena, start or seed_load while busy are ignored.
- mask_o holds its value until the next GEN or pass-through start.
- Asserting rst_n low mid-sample aborts immediately to the reset values. No done pulse is emitted.
- index is 3 bits and never wraps within a sample; the FSM leaves APPLY at index 7.

Decomposition:
- Package dropout_pkg: N_NEURONS, DATA_W, LFSR_W, LFSR_POLY, LFSR_SEED, and the state enum typedef {IDLE, GEN, APPLY, FLUSH}.
- Sub-module dropout_lfsr: seedable Galois LFSR with ports clk, rst_n, load, seed, step, state. The zero-seed substitution lives inside it.
- The FSM, mask register and output register stay in dropout_ctrl.

Test Plan:
- Reset then start, ui_ena=1, rate=0x80, default seed:
  - LFSR post-step upper bytes are E2,71,38,1C,0E,B3,ED,C2.
  - mask_o=0xE1.
  - Inputs 0x11..0x88 produce 0x11,0,0,0,0,0x66,0x77,0x88.
  - done pulses once.
- start with ui_ena=0, inputs 0xA0..0xA7:
  - Outputs equal the inputs, mask_o=0xFF, first in_ready 1 cycle after start.
  - A subsequent training sample still yields mask 0xE1, since the LFSR was not advanced.
- Default seed, rate=0 → mask_o=0xFF. Then rate=0xFF on the next sample → mask_o=0x00 (none of the next 8 upper bytes equal 0xFF).
- seed_load with seed_val=0 in IDLE, followed by rate=0x80 → mask_o=0xE1, proving the zero seed was replaced by LFSR_SEED.
- Backpressure: out_ready low for 3 cycles mid-APPLY:
  - in_ready drops, out_data holds, no beat is lost or duplicated, 8 beats in order.
  - start and seed_load pulses during busy have no effect.
- rst_n asserted on the 4th APPLY beat:
  - All outputs return to reset values in the same cycle, with no done pulse.
  - The next sample reproduces mask 0xE1.

Source files
------------

// File: rtl/dropout_pkg.sv
// dropout_pkg: shared constants, state type and LFSR step
// for the 8-neuron dropout sequencer.
package dropout_pkg;

  localparam int N_NEURONS = 8;
  localparam int DATA_W    = 8;
  localparam int LFSR_W    = 16;
  localparam int IDX_W     = 3;
  localparam int RATE_W    = 8;

  localparam logic [LFSR_W-1:0] LFSR_POLY = 16'hB400;
  localparam logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1;

  localparam logic [IDX_W-1:0] IDX_LAST = 3'd7;

  typedef enum logic [1:0] {
    IDLE,
    GEN,
    APPLY,
    FLUSH
  } state_t;

  // One Galois step, feedback applied when the shifted-out bit is 1.
  function automatic logic [LFSR_W-1:0] lfsr_next(
    input logic [LFSR_W-1:0] s
  );
    return (s >> 1) ^ (s[0] ? LFSR_POLY : '0);
  endfunction

endpackage

// File: rtl/dropout_lfsr.sv
// dropout_lfsr: seedable 16-bit Galois LFSR.
// A zero seed is replaced by LFSR_SEED so the register never locks up.
module dropout_lfsr
  import dropout_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [LFSR_W-1:0] seed,
  input  logic              step,
  output logic [LFSR_W-1:0] state
);

  logic [LFSR_W-1:0] w_seed;

  assign w_seed = (seed == '0) ? LFSR_SEED : seed;

  // Load has priority; otherwise advance one step when asked.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= LFSR_SEED;
    end else if (load) begin
      state <= w_seed;
    end else if (step) begin
      state <= lfsr_next(state);
    end
  end

endmodule

// File: rtl/dropout_ctrl.sv
// dropout_ctrl: per-sample keep-mask generation and masked
// streaming of 8 activations over valid/ready.
module dropout_ctrl
  import dropout_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ui_ena,
  input  logic [RATE_W-1:0]    rate_i,
  input  logic                 seed_load,
  input  logic [LFSR_W-1:0]    seed_val,
  input  logic                 start,
  input  logic                 in_valid,
  input  logic [DATA_W-1:0]    in_data,
  output logic                 in_ready,
  output logic                 out_valid,
  output logic [DATA_W-1:0]    out_data,
  input  logic                 out_ready,
  output logic [N_NEURONS-1:0] mask_o,
  output logic                 busy,
  output logic                 done
);

  state_t                r_state;
  logic [RATE_W-1:0]     r_rate;
  logic [IDX_W-1:0]      r_idx;
  logic [N_NEURONS-1:0]  r_mask;
  logic [DATA_W-1:0]     r_out_data;
  logic                  r_out_valid;
  logic                  r_done;

  logic [LFSR_W-1:0]     w_lfsr;
  logic [LFSR_W-1:0]     w_lfsr_nxt;
  logic                  w_idle;
  logic                  w_seed_ld;
  logic                  w_step;
  logic                  w_keep_bit;
  logic                  w_in_fire;
  logic                  w_out_fire;
  logic                  w_last_idx;

  assign w_idle     = (r_state == IDLE);
  assign w_seed_ld  = w_idle && seed_load;
  assign w_step     = (r_state == GEN);
  assign w_lfsr_nxt = lfsr_next(w_lfsr);
  assign w_last_idx = (r_idx == IDX_LAST);

  // upper byte >= rate  <=>  full word >= {rate, 8'h00}
  assign w_keep_bit = (w_lfsr_nxt >= {r_rate, 8'h00});

  assign in_ready   = (r_state == APPLY)
                   && (!r_out_valid || out_ready);
  assign w_in_fire  = in_valid && in_ready;
  assign w_out_fire = r_out_valid && out_ready;

  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign mask_o     = r_mask;
  assign busy       = !w_idle;
  assign done       = r_done;

  dropout_lfsr u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (w_seed_ld),
    .seed  (seed_val),
    .step  (w_step),
    .state (w_lfsr)
  );

  // Sequencer: sample setup, mask generation, streaming, drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_rate  <= '0;
      r_idx   <= '0;
      r_mask  <= '1;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (seed_load) begin
            r_state <= IDLE;
          end else if (start) begin
            r_idx <= '0;
            if (ui_ena) begin
              r_rate  <= rate_i;
              r_state <= GEN;
            end else begin
              r_mask  <= '1;
              r_state <= APPLY;
            end
          end
        end
        GEN: begin
          r_mask[r_idx] <= w_keep_bit;
          if (w_last_idx) begin
            r_idx   <= '0;
            r_state <= APPLY;
          end else begin
            r_idx <= r_idx + 3'd1;
          end
        end
        APPLY: begin
          if (w_in_fire) begin
            if (w_last_idx) begin
              r_state <= FLUSH;
            end else begin
              r_idx <= r_idx + 3'd1;
            end
          end
        end
        FLUSH: begin
          if (w_out_fire) begin
            r_state <= IDLE;
          end
        end
      endcase
    end
  end

  // Single-entry output register with masked load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else if (w_in_fire) begin
      r_out_valid <= 1'b1;
      r_out_data  <= r_mask[r_idx] ? in_data : '0;
    end else if (w_out_fire) begin
      r_out_valid <= 1'b0;
    end
  end

  // Completion pulse, one cycle after the last beat leaves.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_done <= 1'b0;
    end else begin
      r_done <= (r_state == FLUSH) && w_out_fire;
    end
  end

endmodule

// File: tb/tb_dropout_ctrl.sv
// tb_dropout_ctrl: randomized stimulus checked against a
// behavioural dropout model (LFSR sequence, mask, beat queue).
module tb_dropout_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ui_ena = 1'b0;
  logic [7:0]  rate_i = '0;
  logic        seed_load = 1'b0;
  logic [15:0] seed_val = '0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_ready = 1'b0;
  logic [7:0]  mask_o;
  logic        busy;
  logic        done;

  int          n_chk = 0;
  int          n_fail = 0;
  logic [15:0] m_lfsr = 16'hACE1;
  logic [7:0]  dat [8];
  logic [7:0]  last_em;

  dropout_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ui_ena    (ui_ena),
    .rate_i    (rate_i),
    .seed_load (seed_load),
    .seed_val  (seed_val),
    .start     (start),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .mask_o    (mask_o),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, want);
    end
  endtask

  // Reference generator: halve, fold in the polynomial on odd.
  function automatic logic [15:0] m_step(logic [15:0] s);
    if (s % 2 == 1) return (s / 2) ^ 16'hB400;
    return s / 2;
  endfunction

  task automatic m_mask(input bit ena, input logic [7:0] rate,
                        output logic [7:0] m);
    m = 8'hFF;
    if (ena) begin
      for (int i = 0; i < 8; i++) begin
        m_lfsr = m_step(m_lfsr);
        m[i] = (m_lfsr[15:8] >= rate);
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    start = 1'b0;
    seed_load = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_lfsr = 16'hACE1;
  endtask

  task automatic do_seed(input logic [15:0] val);
    @(negedge clk);
    seed_load = 1'b1;
    seed_val = val;
    start = 1'b1;
    ui_ena = 1'b1;
    @(negedge clk);
    seed_load = 1'b0;
    start = 1'b0;
    chk("seed_blocks_start", busy, 0);
    m_lfsr = (val == 16'h0) ? 16'hACE1 : val;
  endtask

  task automatic run_sample(input bit ena, input logic [7:0] rate,
                            input bit bp, input bit junk);
    logic [7:0] em;
    logic [7:0] want [8];
    logic [7:0] prev_d;
    bit         held;
    int lat, sent, got, budget;
    m_mask(ena, rate, em);
    last_em = em;
    for (int i = 0; i < 8; i++) want[i] = em[i] ? dat[i] : 8'h00;
    @(negedge clk);
    ui_ena = ena;
    rate_i = rate;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ui_ena = 1'($urandom);
    rate_i = 8'($urandom);
    lat = 1;
    while (!in_ready && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("start_to_ready", lat, ena ? 9 : 1);
    chk("mask", mask_o, em);
    sent = 0;
    got = 0;
    budget = 300;
    held = 1'b0;
    prev_d = '0;
    while (got < 8 && budget > 0) begin
      in_valid = (sent < 8) && (!bp || $urandom_range(0, 3) != 0);
      in_data = (sent < 8) ? dat[sent] : 8'h00;
      out_ready = !bp || ($urandom_range(0, 2) != 0);
      if (junk) begin
        start = 1'($urandom);
        seed_load = 1'($urandom);
        seed_val = 16'($urandom);
      end
      #4;
      if (held) chk("data_hold", out_data, prev_d);
      if (out_valid && !out_ready) chk("bp_ready", in_ready, 0);
      held = out_valid && !out_ready;
      prev_d = out_data;
      if (in_valid && in_ready) sent++;
      if (out_valid && out_ready) begin
        chk("beat", out_data, want[got]);
        got++;
      end
      @(negedge clk);
      budget--;
    end
    if (budget == 0) chk("beat_timeout", got, 8);
    in_valid = 1'b0;
    start = 1'b0;
    seed_load = 1'b0;
    chk("done_pulse", done, 1);
    chk("idle_after", busy, 0);
    chk("sent_count", sent, 8);
    @(negedge clk);
    chk("done_single", done, 0);
    chk("no_extra_beat", out_valid, 0);
    chk("mask_hold", mask_o, em);
  endtask

  task automatic reset_mid_sample();
    int sent;
    int lat;
    @(negedge clk);
    ui_ena = 1'b1;
    rate_i = 8'h80;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (!in_ready && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    out_ready = 1'b1;
    sent = 0;
    while (sent < 3) begin
      in_valid = 1'b1;
      in_data = dat[sent];
      #4;
      if (in_ready) sent++;
      @(negedge clk);
    end
    in_valid = 1'b1;
    in_data = dat[3];
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_mask", mask_o, 8'hFF);
    in_valid = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m_lfsr = 16'hACE1;
    repeat (3) begin
      @(negedge clk);
      chk("rst_no_done", done, 0);
    end
  endtask

  initial begin
    do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_data", out_data, 0);
    chk("reset_in_ready", in_ready, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_mask", mask_o, 8'hFF);
    rst_n = 1'b1;
    m_lfsr = 16'hACE1;

    for (int i = 0; i < 8; i++) dat[i] = 8'(8'h11 * (i + 1));
    run_sample(1'b1, 8'h80, 1'b0, 1'b0);
    chk("first_mask_e1", last_em, 8'hE1);

    do_reset();
    for (int i = 0; i < 8; i++) dat[i] = 8'(8'hA0 + i);
    run_sample(1'b0, 8'h80, 1'b0, 1'b0);
    run_sample(1'b1, 8'h80, 1'b0, 1'b0);
    chk("pass_keeps_lfsr", mask_o, 8'hE1);

    do_reset();
    run_sample(1'b1, 8'h00, 1'b0, 1'b0);
    chk("rate0_all_keep", mask_o, 8'hFF);
    run_sample(1'b1, 8'hFF, 1'b0, 1'b0);

    do_seed(16'h0000);
    run_sample(1'b1, 8'h80, 1'b0, 1'b0);
    chk("zero_seed_e1", mask_o, 8'hE1);

    for (int i = 0; i < 8; i++) dat[i] = 8'($urandom);
    run_sample(1'b1, 8'h60, 1'b1, 1'b1);
    run_sample(1'b0, 8'h60, 1'b1, 1'b1);

    do_reset();
    reset_mid_sample();
    run_sample(1'b1, 8'h80, 1'b0, 1'b0);
    chk("after_abort_e1", mask_o, 8'hE1);

    for (int n = 0; n < 16; n++) begin
      if ($urandom_range(0, 3) == 0) do_seed(16'($urandom));
      for (int i = 0; i < 8; i++) dat[i] = 8'($urandom);
      run_sample(1'($urandom), 8'($urandom), 1'($urandom),
                 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
